// File: rtl/tut4_verilog_sort_iter_sorter.sv
// Iterative four-element sorter built around a single min/max comparator.
//
// A set of four unsigned p_nbits values is accepted in IDLE, sorted in
// place over a fixed six-step bubble-sort schedule (three passes of 3, 2
// and 1 compare/exchange steps), and presented in ascending order in DONE.
//
// Optional feature: define TUT4_VERILOG_SORT_ITER_SORTER_EARLY_EXIT_EN to
// add a sticky per-pass swap flag. A pass that completes without any swap
// means the set is already sorted, so the FSM jumps straight to DONE.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. in_rdy and out_val are decoded from the state register only (no
// path from in_val or out_rdy) and are held low while reset is asserted.

// Single unsigned min/max comparator. Equal operands keep their order.
module tut4_verilog_sort_iter_minmax #(
  parameter int p_nbits = 8
) (
  input  logic [p_nbits-1:0] in0,
  input  logic [p_nbits-1:0] in1,
  output logic [p_nbits-1:0] out_min,
  output logic [p_nbits-1:0] out_max
);

  logic gt;

  assign gt      = (in0 > in1);
  assign out_min = gt ? in1 : in0;
  assign out_max = gt ? in0 : in1;

endmodule

module tut4_verilog_sort_iter_sorter #(
  parameter int p_nbits = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in_val,
  output logic               in_rdy,
  input  logic [p_nbits-1:0] in0,
  input  logic [p_nbits-1:0] in1,
  input  logic [p_nbits-1:0] in2,
  input  logic [p_nbits-1:0] in3,
  output logic               out_val,
  input  logic               out_rdy,
  output logic [p_nbits-1:0] out0,
  output logic [p_nbits-1:0] out1,
  output logic [p_nbits-1:0] out2,
  output logic [p_nbits-1:0] out3,
  output logic [1:0]         dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SORT = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t             state;
  logic [p_nbits-1:0] r [4];
  logic [2:0]         cnt;
  logic [1:0]         lo;
  logic [1:0]         hi;
  logic [p_nbits-1:0] cmp_in0;
  logic [p_nbits-1:0] cmp_in1;
  logic [p_nbits-1:0] cmp_min;
  logic [p_nbits-1:0] cmp_max;

  // Bubble-sort schedule: cnt 0,1,2 -> pairs 0,1,2; cnt 3,4 -> 0,1; cnt 5 -> 0.
  always_comb begin
    lo = 2'd0;
    case (cnt)
      3'd1:    lo = 2'd1;
      3'd2:    lo = 2'd2;
      3'd4:    lo = 2'd1;
      default: lo = 2'd0;
    endcase
  end

  assign hi      = lo + 2'd1;
  assign cmp_in0 = r[lo];
  assign cmp_in1 = r[hi];

  tut4_verilog_sort_iter_minmax #(
    .p_nbits (p_nbits)
  ) u_minmax (
    .in0     (cmp_in0),
    .in1     (cmp_in1),
    .out_min (cmp_min),
    .out_max (cmp_max)
  );

`ifdef TUT4_VERILOG_SORT_ITER_SORTER_EARLY_EXIT_EN
  logic swap_flag;
  logic step_swap;
  logic pass_swap;

  // A swap happened exactly when the smaller value is not the left operand.
  assign step_swap = (cmp_min != cmp_in0);
  // The flag restarts at the first step of each pass (cnt 0 and 3).
  assign pass_swap = step_swap |
                     (((cnt == 3'd0) || (cnt == 3'd3)) ? 1'b0 : swap_flag);
`endif

  // Control FSM, step counter and element registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= 3'd0;
      r[0]  <= '0;
      r[1]  <= '0;
      r[2]  <= '0;
      r[3]  <= '0;
`ifdef TUT4_VERILOG_SORT_ITER_SORTER_EARLY_EXIT_EN
      swap_flag <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_val) begin
            r[0]  <= in0;
            r[1]  <= in1;
            r[2]  <= in2;
            r[3]  <= in3;
            cnt   <= 3'd0;
            state <= SORT;
          end
        end
        SORT: begin
          r[lo] <= cmp_min;
          r[hi] <= cmp_max;
          cnt   <= cnt + 3'd1;
`ifdef TUT4_VERILOG_SORT_ITER_SORTER_EARLY_EXIT_EN
          swap_flag <= pass_swap;
          if (cnt == 3'd5) begin
            state <= DONE;
          end else if (((cnt == 3'd2) || (cnt == 3'd4)) && !pass_swap) begin
            state <= DONE;
          end
`else
          if (cnt == 3'd5) begin
            state <= DONE;
          end
`endif
        end
        DONE: begin
          if (out_rdy) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_rdy    = reset && (state == IDLE);
  assign out_val   = reset && (state == DONE);
  assign out0      = r[0];
  assign out1      = r[1];
  assign out2      = r[2];
  assign out3      = r[3];
  assign dbg_state = state;

endmodule

// File: tb/tb_tut4_verilog_sort_iter_sorter.sv
// Bench for the iterative four-element sorter: table of vectors with
// expected sorted outputs, a scoreboard queue, and hand-written reset and
// back-pressure sequences.
module tb_tut4_verilog_sort_iter_sorter;

`ifdef TUT4_VERILOG_SORT_ITER_SORTER_EARLY_EXIT_EN
  localparam bit EARLY_EN = 1'b1;
`else
  localparam bit EARLY_EN = 1'b0;
`endif

  logic       clk;
  logic       reset;
  logic       in_val;
  logic       in_rdy;
  logic [7:0] in0, in1, in2, in3;
  logic       out_val;
  logic       out_rdy;
  logic [7:0] out0, out1, out2, out3;
  logic [1:0] dbg_state;

  int pass_cnt;
  int total_cnt;

  logic [31:0] exp_q[$];

  typedef struct {
    logic [31:0] v;      // {in3,in2,in1,in0}
    logic [31:0] e;      // {out3,out2,out1,out0}
    int          stall;  // cycles of out_rdy=0 after out_val rises
  } vec_t;

  vec_t tbl[$];

  tut4_verilog_sort_iter_sorter #(.p_nbits(8)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_val    (in_val),
    .in_rdy    (in_rdy),
    .in0       (in0),
    .in1       (in1),
    .in2       (in2),
    .in3       (in3),
    .out_val   (out_val),
    .out_rdy   (out_rdy),
    .out0      (out0),
    .out1      (out1),
    .out2      (out2),
    .out3      (out3),
    .dbg_state (dbg_state)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference sort by ranking (stable for duplicates).
  function automatic logic [31:0] sort4(input logic [31:0] v);
    logic [7:0] a[4];
    logic [7:0] o[4];
    int p;
    for (int i = 0; i < 4; i++) a[i] = v[i*8 +: 8];
    for (int i = 0; i < 4; i++) begin
      p = 0;
      for (int j = 0; j < 4; j++)
        if ((a[j] < a[i]) || ((a[j] == a[i]) && (j < i))) p++;
      o[p] = a[i];
    end
    return {o[3], o[2], o[1], o[0]};
  endfunction

  // Cycles from input fire to out_val; shorter when an early pass is swap-free.
  function automatic int exp_lat(input logic [31:0] v);
    logic [7:0] a[4];
    logic [7:0] t;
    bit sw;
    for (int i = 0; i < 4; i++) a[i] = v[i*8 +: 8];
    if (EARLY_EN) begin
      sw = 1'b0;
      for (int k = 0; k < 3; k++)
        if (a[k] > a[k+1]) begin t = a[k]; a[k] = a[k+1]; a[k+1] = t; sw = 1'b1; end
      if (!sw) return 4;
      sw = 1'b0;
      for (int k = 0; k < 2; k++)
        if (a[k] > a[k+1]) begin t = a[k]; a[k] = a[k+1]; a[k+1] = t; sw = 1'b1; end
      if (!sw) return 6;
    end
    return 7;
  endfunction

  // Present a set until it is accepted; returns after the accepting edge.
  task automatic drive_set(input logic [31:0] v, input logic [31:0] e, input string tag);
    int waitc;
    @(negedge clk);
    in0 = v[7:0]; in1 = v[15:8]; in2 = v[23:16]; in3 = v[31:24];
    in_val = 1'b1;
    waitc = 0;
    while (!in_rdy && waitc < 20) begin
      @(negedge clk);
      waitc++;
    end
    check({tag, " in_rdy_before_fire"}, {31'd0, in_rdy}, 32'd1);
    exp_q.push_back(e);
    @(negedge clk);
    // Keep in_val high with junk while busy: it must be ignored.
    in0 = 8'($urandom_range(0, 255)); in1 = 8'($urandom_range(0, 255));
    in2 = 8'($urandom_range(0, 255)); in3 = 8'($urandom_range(0, 255));
  endtask

  // Full transaction: drive, wait for result, optional back-pressure, consume.
  task automatic run_vec(input logic [31:0] v, input logic [31:0] e, input int stall, input string tag);
    int lat;
    logic [31:0] exp;
    drive_set(v, e, tag);
    lat = 1;
    while (!out_val && lat < 20) begin
      check({tag, " in_rdy_busy"}, {31'd0, in_rdy}, 32'd0);
      @(negedge clk);
      lat++;
    end
    in_val = 1'b0;
    check({tag, " latency"}, lat, exp_lat(v));
    check({tag, " in_rdy_done"}, {31'd0, in_rdy}, 32'd0);
    exp = (exp_q.size() > 0) ? exp_q[0] : 32'hdeadbeef;
    for (int s = 0; s < stall; s++) begin
      check({tag, " out_val_held"}, {31'd0, out_val}, 32'd1);
      check({tag, " out_held"}, {out3, out2, out1, out0}, exp);
      @(negedge clk);
    end
    out_rdy = 1'b1;
    check({tag, " out_val"}, {31'd0, out_val}, 32'd1);
    if (exp_q.size() > 0) exp = exp_q.pop_front();
    check({tag, " out_data"}, {out3, out2, out1, out0}, exp);
    @(negedge clk);
    out_rdy = 1'b0;
    check({tag, " out_val_after"}, {31'd0, out_val}, 32'd0);
    check({tag, " in_rdy_after"}, {31'd0, in_rdy}, 32'd1);
  endtask

  initial begin
    logic [31:0] rv;
    pass_cnt  = 0;
    total_cnt = 0;
    reset   = 1'b0;
    in_val  = 1'b0;
    out_rdy = 1'b0;
    in0 = 8'd0; in1 = 8'd0; in2 = 8'd0; in3 = 8'd0;

    tbl.push_back('{v: 32'h10203040, e: 32'h40302010, stall: 0});  // reverse
    tbl.push_back('{v: 32'h00ff00ff, e: 32'hffff0000, stall: 0});  // dupes/extremes
    tbl.push_back('{v: 32'h00020103, e: 32'h03020100, stall: 5});  // back-pressure
    tbl.push_back('{v: 32'h04030201, e: 32'h04030201, stall: 0});  // already sorted
    tbl.push_back('{v: 32'h04030102, e: 32'h04030201, stall: 0});  // one swap
    tbl.push_back('{v: 32'h07070707, e: 32'h07070707, stall: 1});  // all equal
    for (int i = 0; i < 8; i++) begin
      rv = $urandom();
      tbl.push_back('{v: rv, e: sort4(rv), stall: $urandom_range(0, 3)});
    end

    // Reset, then idle
    @(negedge clk);
    check("reset_in_rdy", {31'd0, in_rdy}, 32'd0);
    check("reset_out_val", {31'd0, out_val}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("idle_in_rdy", {31'd0, in_rdy}, 32'd1);
    check("idle_out_val", {31'd0, out_val}, 32'd0);
    check("idle_outs", {out3, out2, out1, out0}, 32'd0);

    // Table-driven vectors
    foreach (tbl[i]) run_vec(tbl[i].v, tbl[i].e, tbl[i].stall, $sformatf("vec%0d", i));

    // Reset mid-sort: in-flight set is discarded
    drive_set(32'h06070809, 32'h09080706, "midrst");
    in_val = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("midrst_in_rdy", {31'd0, in_rdy}, 32'd0);
    check("midrst_out_val", {31'd0, out_val}, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    check("midrst_idle_in_rdy", {31'd0, in_rdy}, 32'd1);
    check("midrst_idle_out_val", {31'd0, out_val}, 32'd0);
    check("midrst_cleared", {out3, out2, out1, out0}, 32'd0);
    run_vec(32'h02030401, 32'h04030201, 0, "postrst");

    // Idle stays idle: no stray output
    repeat (3) begin
      @(negedge clk);
      check("tail_out_val", {31'd0, out_val}, 32'd0);
    end
    check("scoreboard_empty", exp_q.size(), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
